// File: rtl/pe_buffer_manager_if.sv
// pe_buffer_manager_if: host and PE side signals of the PE task/result buffer manager
interface pe_buffer_manager_if #(
  parameter int TBB_DATA_WIDTH = 32,
  parameter int TBB_ADDR_WIDTH = 16,
  parameter int RBB_DATA_WIDTH = 512,
  parameter int RBB_ADDR_WIDTH = 8
);
  logic                      host_tbbWrEn;
  logic [TBB_ADDR_WIDTH-1:0] host_tbbWrAddr;
  logic [TBB_DATA_WIDTH-1:0] host_tbbWrDin;
  logic                      host_go;
  logic                      bm2host_busy;
  logic                      bm2host_rdValid;
  logic                      host_rdReady;
  logic [RBB_DATA_WIDTH-1:0] bm2host_rdData;
  logic                      bm2host_rdLast;
  logic [RBB_ADDR_WIDTH:0]   bm2host_wrCount;
  logic                      bm2pe_start;
  logic                      pe2bm_done;
  logic                      pe2bm_rbbWrEn;
  logic [RBB_ADDR_WIDTH-1:0] pe2bm_rbbWrAddr;
  logic [RBB_DATA_WIDTH-1:0] pe2bm_rbbWrDin;
  logic [TBB_ADDR_WIDTH-1:0] pe2bm_tbbRdAddr;
  logic [TBB_DATA_WIDTH-1:0] bm2pe_tbbRdDout;
  modport slave (
    input  host_tbbWrEn, host_tbbWrAddr, host_tbbWrDin, host_go, host_rdReady,
    input  pe2bm_done, pe2bm_rbbWrEn, pe2bm_rbbWrAddr, pe2bm_rbbWrDin, pe2bm_tbbRdAddr,
    output bm2host_busy, bm2host_rdValid, bm2host_rdData, bm2host_rdLast, bm2host_wrCount,
    output bm2pe_start, bm2pe_tbbRdDout
  );
  modport master (
    output host_tbbWrEn, host_tbbWrAddr, host_tbbWrDin, host_go, host_rdReady,
    output pe2bm_done, pe2bm_rbbWrEn, pe2bm_rbbWrAddr, pe2bm_rbbWrDin, pe2bm_tbbRdAddr,
    input  bm2host_busy, bm2host_rdValid, bm2host_rdData, bm2host_rdLast, bm2host_wrCount,
    input  bm2pe_start, bm2pe_tbbRdDout
  );
endinterface

// File: rtl/pe_buffer_manager.sv
// pe_buffer_manager: owns TBB/RBB memories, runs one PE and drains its results to the host
module pe_buffer_manager #(
  parameter int TBB_DATA_WIDTH = 32,
  parameter int TBB_ADDR_WIDTH = 16,
  parameter int RBB_DATA_WIDTH = 512,
  parameter int RBB_ADDR_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  pe_buffer_manager_if.slave bus
);
  localparam int NUM_RBB = 2 ** RBB_ADDR_WIDTH;
  localparam logic [RBB_ADDR_WIDTH:0] FULL = RBB_ADDR_WIDTH'(0) + (RBB_ADDR_WIDTH+1)'(NUM_RBB);
  localparam logic [RBB_ADDR_WIDTH-1:0] LAST_IDX = '1;
  typedef enum logic [1:0] {IDLE, START, RUN, DRAIN} state_t;
  state_t state;
  logic [TBB_DATA_WIDTH-1:0] tbb [2**TBB_ADDR_WIDTH];
  logic [RBB_DATA_WIDTH-1:0] rbb [NUM_RBB];
  logic [RBB_ADDR_WIDTH-1:0] out_idx, next_idx;
  logic [RBB_ADDR_WIDTH:0]   wr_count;
  logic [RBB_DATA_WIDTH-1:0] rd_data;
  logic [TBB_DATA_WIDTH-1:0] tbb_dout;
  logic                      busy, start, rd_valid, rd_last;
  assign next_idx = out_idx + 1'b1;
  assign bus.bm2host_busy    = busy;
  assign bus.bm2host_rdValid = rd_valid;
  assign bus.bm2host_rdData  = rd_data;
  assign bus.bm2host_rdLast  = rd_last;
  assign bus.bm2host_wrCount = wr_count;
  assign bus.bm2pe_start     = start;
  assign bus.bm2pe_tbbRdDout = tbb_dout;
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.host_tbbWrEn) tbb[bus.host_tbbWrAddr] <= bus.host_tbbWrDin;
    if (state == RUN && bus.pe2bm_rbbWrEn) rbb[bus.pe2bm_rbbWrAddr] <= bus.pe2bm_rbbWrDin;
  end
  // The RBB read register doubles as the drain output register: on a stall the same entry is held.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      busy     <= 1'b0;
      start    <= 1'b0;
      rd_valid <= 1'b0;
      rd_last  <= 1'b0;
      rd_data  <= '0;
      out_idx  <= '0;
      wr_count <= '0;
      tbb_dout <= '0;
    end else begin
      tbb_dout <= tbb[bus.pe2bm_tbbRdAddr];
      start    <= 1'b0;
      case (state)
        IDLE: if (bus.host_go) begin
          state <= START;
          start <= 1'b1;
          busy  <= 1'b1;
        end
        START: begin
          state    <= RUN;
          wr_count <= '0;
        end
        RUN: begin
          if (bus.pe2bm_rbbWrEn && wr_count != FULL) wr_count <= wr_count + 1'b1;
          if (bus.pe2bm_done) state <= DRAIN;
        end
        DRAIN: if (!rd_valid) begin
          rd_data  <= rbb[0];
          out_idx  <= '0;
          rd_valid <= 1'b1;
          rd_last  <= 1'b0;
        end else if (bus.host_rdReady) begin
          if (rd_last) begin
            rd_valid <= 1'b0;
            rd_last  <= 1'b0;
            busy     <= 1'b0;
            state    <= IDLE;
          end else begin
            rd_data <= rbb[next_idx];
            out_idx <= next_idx;
            rd_last <= next_idx == LAST_IDX;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
